// File: rtl/key_debouncer.sv
// Conditions a raw pushbutton pin into a clean debounced level, one-cycle
// press/release/long-press pulses and a wrapping press counter.
module key_debouncer #(
    parameter int DEBOUNCE_MAX   = 999999,
    parameter int LONG_PRESS_MAX = 49999999,
    parameter int ACTIVE_LOW     = 1,
    parameter int CNT_W          = 8
) (
    input  logic             fpga_clk_50,
    input  logic             hps_fpga_reset_n,
    input  logic             key_in,
    output logic             key_level,
    output logic             key_press,
    output logic             key_release,
    output logic             key_long,
    output logic [CNT_W-1:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_MAX + 1);
    localparam int LW = $clog2(LONG_PRESS_MAX + 1);

    localparam logic [DW-1:0] DB_MAX_C   = DW'(DEBOUNCE_MAX);
    localparam logic [LW-1:0] LONG_MAX_C = LW'(LONG_PRESS_MAX);
    localparam logic          POL_C      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync2_q;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;
    logic             long_flag_q, long_flag_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pressed_s;

    // Synchronized pin normalised so that 1 always means "pressed".
    assign pressed_s = sync2_q ^ POL_C;

    // Synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge fpga_clk_50) begin
        if (!hps_fpga_reset_n) begin
            sync1_q     <= POL_C;
            sync2_q     <= POL_C;
            state_q     <= ST_IDLE;
            dcnt_q      <= '0;
            lcnt_q      <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            sync1_q     <= key_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            lcnt_q      <= lcnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            count_q     <= count_d;
        end
    end

    // Next-state and next-output logic for the debounce FSM.
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        lcnt_d      = lcnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = count_q;

        case (state_q)
            ST_IDLE: begin
                dcnt_d = '0;
                if (pressed_s) begin
                    state_d = ST_DB_PRESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DB_PRESS: begin
                if (!pressed_s) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DB_MAX_C) begin
                    state_d     = ST_PRESSED;
                    dcnt_d      = '0;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    count_d     = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    lcnt_d      = '0;
                    long_flag_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
                end
            end

            ST_PRESSED: begin
                // The hold timer saturates so only one long pulse fires per press.
                if ((lcnt_q == LONG_MAX_C) && !long_flag_q) begin
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                end else if (lcnt_q < LONG_MAX_C) begin
                    lcnt_d = lcnt_q + {{(LW-1){1'b0}}, 1'b1};
                end else begin
                    lcnt_d = lcnt_q;
                end
                if (!pressed_s) begin
                    state_d = ST_DB_RELEASE;
                    dcnt_d  = '0;
                end else begin
                    state_d = ST_PRESSED;
                end
            end

            ST_DB_RELEASE: begin
                if (pressed_s) begin
                    state_d = ST_PRESSED;
                end else if (dcnt_q == DB_MAX_C) begin
                    state_d     = ST_IDLE;
                    dcnt_d      = '0;
                    release_d   = 1'b1;
                    level_d     = 1'b0;
                    long_flag_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + {{(DW-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = ST_IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign press_count = count_q;

endmodule

// File: tb/tb_key_debouncer.sv
// Randomized scoreboard bench for key_debouncer: a run-length reference model
// queues the expected output word per clock; a monitor pops and compares.
module tb_key_debouncer;

    localparam int DM = 15;
    localparam int LM = 99;
    localparam int CW = 8;

    logic          fpga_clk_50 = 1'b0;
    logic          hps_fpga_reset_n;
    logic          key_in;
    logic          key_level, key_press, key_release, key_long;
    logic [CW-1:0] press_count;

    key_debouncer #(
        .DEBOUNCE_MAX(DM), .LONG_PRESS_MAX(LM), .ACTIVE_LOW(1), .CNT_W(CW)
    ) dut (
        .fpga_clk_50(fpga_clk_50),
        .hps_fpga_reset_n(hps_fpga_reset_n),
        .key_in(key_in),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long),
        .press_count(press_count)
    );

    always #5 fpga_clk_50 = ~fpga_clk_50;

    typedef struct packed {
        logic          level;
        logic          press;
        logic          rel;
        logic          lng;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Observed DUT pulses, for directed checks.
    int n_press = 0, n_rel = 0, n_long = 0;
    int mon_cyc = 0, press_cyc = 0, long_cyc = 0;

    // Reference model: pressed samples pass through a two-deep delay; the
    // debounced level flips once the opposite level has been seen DM+2 times
    // in a row; long fires on the (LM+1)th held sample after the press.
    logic          m_p1, m_p2, m_prev, m_level, m_longdone;
    int            m_run, m_held;
    logic [CW-1:0] m_cnt;

    task automatic model_edge(input logic rst_v, input logic key_v);
        exp_t e;
        logic s;
        e = '0;
        if (!rst_v) begin
            m_p1 = 1'b0; m_p2 = 1'b0; m_prev = 1'b0; m_level = 1'b0;
            m_longdone = 1'b0; m_run = 0; m_held = 0; m_cnt = '0;
        end else begin
            s = m_p2;
            if (!m_level) begin
                m_run = s ? m_run + 1 : 0;
                if (m_run == DM + 2) begin
                    m_level = 1'b1; e.press = 1'b1; m_cnt = m_cnt + 8'd1;
                    m_run = 0; m_held = 0; m_longdone = 1'b0;
                end
            end else begin
                if (m_prev) begin
                    m_held = m_held + 1;
                    if (m_held == LM + 1 && !m_longdone) begin
                        e.lng = 1'b1; m_longdone = 1'b1;
                    end
                end
                m_run = s ? 0 : m_run + 1;
                if (m_run == DM + 2) begin
                    m_level = 1'b0; e.rel = 1'b1; m_run = 0;
                end
            end
            m_prev = s;
            m_p2 = m_p1;
            m_p1 = ~key_v;
        end
        e.level = m_level;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic rst_v, input logic key_v);
        hps_fpga_reset_n = rst_v;
        key_in = key_v;
        @(posedge fpga_clk_50);
        model_edge(rst_v, key_v);
        @(negedge fpga_clk_50);
        #1;
    endtask

    task automatic hold(input logic key_v, input int n);
        for (int i = 0; i < n; i++) step(1'b1, key_v);
    endtask

    task automatic clr();
        n_press = 0; n_rel = 0; n_long = 0;
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_cmp++;
        if (got != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: one expected word per clock, compared on the falling edge.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge fpga_clk_50);
            mon_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = {key_level, key_press, key_release, key_long, press_count};
                n_cmp++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL cycle_out cyc=%0d got lvl=%b prs=%b rel=%b lng=%b cnt=%0d, expected lvl=%b prs=%b rel=%b lng=%b cnt=%0d",
                             mon_cyc, g.level, g.press, g.rel, g.lng, g.cnt,
                             e.level, e.press, e.rel, e.lng, e.cnt);
                end
            end
            if (key_press === 1'b1) begin n_press++; press_cyc = mon_cyc; end
            if (key_release === 1'b1) n_rel++;
            if (key_long === 1'b1) begin n_long++; long_cyc = mon_cyc; end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic kv;
        int   r;
        hps_fpga_reset_n = 1'b0;
        key_in = 1'b1;

        // 1: reset with key held, key stays held after release
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        clr();
        hold(1'b0, 30);
        check("t1_press_pulses", n_press, 1);
        check("t1_level", int'(key_level), 1);
        check("t1_count", int'(press_count), 1);
        hold(1'b1, 30);

        // 2: clean press, 40-cycle hold, clean release
        clr();
        hold(1'b0, 40);
        hold(1'b1, 30);
        check("t2_press", n_press, 1);
        check("t2_release", n_rel, 1);
        check("t2_long", n_long, 0);

        // 3: glitch shorter than the debounce window
        clr();
        hold(1'b0, 10);
        hold(1'b1, 20);
        check("t3_pulses", n_press + n_rel + n_long, 0);
        check("t3_level", int'(key_level), 0);
        check("t3_count", int'(press_count), 2);

        // 4: bounce on release
        hold(1'b0, 30);
        clr();
        hold(1'b1, 5);
        hold(1'b0, 3);
        hold(1'b1, 30);
        check("t4_release", n_rel, 1);
        check("t4_press", n_press, 0);
        check("t4_count", int'(press_count), 3);

        // 5: long hold, then a short press, then a just-long-enough press
        clr();
        hold(1'b0, 300);
        check("t5_long", n_long, 1);
        check("t5_long_delay", long_cyc - press_cyc, LM + 1);
        check("t5_level", int'(key_level), 1);
        check("t5_no_release", n_rel, 0);
        hold(1'b1, 30);
        check("t5_release", n_rel, 1);
        clr();
        hold(1'b0, 60);
        hold(1'b1, 30);
        check("t5_short_no_long", n_long, 0);
        clr();
        hold(1'b0, 130);
        hold(1'b1, 30);
        check("t5_second_long", n_long, 1);

        // 6: counter wrap, then reset during press debounce
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        hold(1'b1, 5);
        for (int i = 0; i < 257; i++) begin
            hold(1'b0, 20);
            hold(1'b1, 20);
        end
        check("t6_wrap_count", int'(press_count), 1);
        clr();
        hold(1'b0, 8);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        hold(1'b1, 30);
        check("t6_abort_pulses", n_press, 0);
        check("t6_abort_count", int'(press_count), 0);

        // 7: randomized bursts, bounces, long holds and occasional resets
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            kv = ($urandom_range(0, 1) == 1);
            if (r < 3) begin
                step(1'b0, kv);
                step(1'b0, kv);
            end else if (r < 15) begin
                hold(1'b0, int'($urandom_range(100, 180)));
            end else begin
                hold(kv, int'($urandom_range(1, 40)));
            end
        end
        hold(1'b1, 40);

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Input-side counterpart to the LED output driver: conditions a raw pushbutton/switch pin (DE0-Nano-SoC KEYs, active-low) into a clean level plus single-cycle press/release/long-press event pulses.
- Also keeps a running press count.
- Sits between the top-level KEY pins and fabric logic or HPS-visible registers, in the fpga_clk_50 domain.

Parameters:
- DEBOUNCE_MAX, 999999: debounce window terminal count. The window is DEBOUNCE_MAX+1 clocks, 20 ms at 50 MHz. Must be >= 1.
- LONG_PRESS_MAX, 49999999: long-press terminal count. The threshold is LONG_PRESS_MAX+1 clocks after key_press, 1 s at 50 MHz. Must be >= 1.
- ACTIVE_LOW, 1: 1 = key_in low means pressed; 0 = key_in high means pressed.
- CNT_W, 8: width of press_count.

Ports:
- fpga_clk_50, input, 1: sole clock.
- hps_fpga_reset_n, input, 1: reset, synchronous, active-low.
- key_in, input, 1: raw asynchronous pin.
- key_level, output, 1: debounced state, 1 = pressed.
- key_press, output, 1: one-cycle pulse on debounced press.
- key_release, output, 1: one-cycle pulse on debounced release.
- key_long, output, 1: one-cycle pulse when a press has been held LONG_PRESS_MAX+1 clocks.
- press_count, output, CNT_W: number of debounced presses, wraps modulo 2^CNT_W.

Behaviour:

Reset:
- Sampled only on a rising edge while hps_fpga_reset_n=0.
- key_level=0, key_press=0, key_release=0, key_long=0, press_count=0.
- Both synchronizer flops load the inactive pin level (1 if ACTIVE_LOW, else 0).
- Debounce counter=0, long counter=0, long flag=0, state=IDLE.
- Reset asserted mid-debounce or mid-press aborts with no pulse emitted.
- A key held across reset release is debounced afresh and produces a normal key_press.

Synchronizer and normalisation:
- Two-flop synchronizer on key_in.
- pressed = sync_out XOR ACTIVE_LOW.

Counter widths:
- Debounce and long counters sized $clog2(max+1).
- All outputs are registered.

FSM (4 states):
- IDLE: if pressed, go to DB_PRESS with dcnt=0.
- DB_PRESS:
  - If !pressed: go to IDLE, dcnt=0 (glitch rejected, no pulse).
  - Else if dcnt==DEBOUNCE_MAX: go to PRESSED. key_press=1 for one cycle, key_level<=1, press_count<=press_count+1 (wraps), lcnt=0, long flag=0.
  - Else dcnt++.
- PRESSED:
  - If lcnt==LONG_PRESS_MAX and long flag=0: key_long=1 for one cycle, long flag<=1. lcnt saturates and does not wrap.
  - Else if lcnt<LONG_PRESS_MAX: lcnt++.
  - If !pressed: go to DB_RELEASE with dcnt=0. The long check still evaluates in that same cycle.
- DB_RELEASE:
  - lcnt is held.
  - If pressed: return to PRESSED (bounce). No pulse; key_level stays 1; lcnt resumes.
  - Else if dcnt==DEBOUNCE_MAX: go to IDLE. key_release=1 for one cycle, key_level<=0, long flag<=0.
  - Else dcnt++.

Latency:
- Let the first rising edge at which key_in shows the pressed level be edge 1, with the input stable thereafter.
- key_press and key_level go high on edge DEBOUNCE_MAX+4.
- Release is symmetric: key_release goes high and key_level goes low on edge DEBOUNCE_MAX+4 after the release level is first sampled.
- key_long goes high LONG_PRESS_MAX+1 clocks after the key_press edge, provided there was no bounce.

Pulse rules:
- key_press, key_release and key_long are never simultaneously high.
- key_press and key_release never occur in consecutive cycles.
- At most one key_long per press.

Test Plan:
(bench parameters: DEBOUNCE_MAX=15, LONG_PRESS_MAX=99, ACTIVE_LOW=1, CNT_W=8)
1. Reset held 4 cycles with key_in=0 (pressed), then released, key_in held 0 -> all outputs 0 during reset; key_press pulses on edge 19 after release; key_level=1; press_count=1.
2. Clean press, hold 40 cycles, clean release -> key_press 1 cycle at edge 19; key_release 1 cycle at edge 19 after the release sample; key_level high between them; no key_long.
3. Glitch: key_in low for 10 cycles then high -> no pulses, key_level stays 0, FSM back in IDLE, press_count unchanged.
4. Bounce on release: after press, key_in high 5 cycles, low 3, then high stable -> single key_release at 19 edges after the final high sample; no second key_press; press_count unchanged.
5. Long hold of 300 cycles -> exactly one key_long, 100 clocks after key_press; key_level stays 1; key_release only after the hold ends; a second press gives no key_long unless it is held >= 100 clocks.
6. 257 clean press/release cycles -> press_count reads 1 after wrap; reset asserted mid-DB_PRESS yields no pulse and press_count=0.
